// File: rtl/sign_extend_pkg.sv
// Shared definitions for the immediate-extension unit.
//   ext_mode_t : extension mode encodings (sign, zero, upper, reserved)
//   IMM_W      : default instruction immediate width
//   WORD_W     : default datapath word width
package sign_extend_pkg;

  localparam int unsigned IMM_W  = 16;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    EXT_SIGN  = 2'b00,
    EXT_ZERO  = 2'b01,
    EXT_UPPER = 2'b10,
    EXT_RSVD  = 2'b11
  } ext_mode_t;

endpackage : sign_extend_pkg

// File: rtl/sign_extend_ext_core.sv
// ext_core: combinational mode mux that widens an IN_W immediate to OUT_W bits.
// Ports:
//   input_data  in  IN_W   immediate field
//   ext_mode    in  2      00 sign, 01 zero, 10 upper, 11 reserved (as sign)
//   output_data out OUT_W  extended result, combinational
module ext_core
  import sign_extend_pkg::*;
#(
  parameter int unsigned IN_W  = IMM_W,
  parameter int unsigned OUT_W = WORD_W
) (
  input  logic [IN_W-1:0]  input_data,
  input  logic [1:0]       ext_mode,
  output logic [OUT_W-1:0] output_data
);

  localparam int unsigned EXT_W = OUT_W - IN_W;

  ext_mode_t mode;

  assign mode = ext_mode_t'(ext_mode);

  // Mode select; reserved encoding deliberately falls through to sign extension.
  always_comb begin
    output_data = {{EXT_W{input_data[IN_W-1]}}, input_data};
    case (mode)
      EXT_ZERO:  output_data = {{EXT_W{1'b0}}, input_data};
      EXT_UPPER: output_data = {input_data, {EXT_W{1'b0}}};
      default:   output_data = {{EXT_W{input_data[IN_W-1]}}, input_data};
    endcase
  end

endmodule : ext_core

// File: rtl/sign_extend.sv
// sign_extend: immediate-extension unit of the multicycle datapath.
// Combinational result for the ALU-B mux plus a registered copy that holds the
// immediate across decode -> execute/branch states.
// Optional feature macro: SIGN_EXTEND_SHIFT2_EN adds branch_off (result << 2)
// and an internal registered copy of it.
// Ports:
//   clk          in   1      system clock, rising edge
//   reset        in   1      synchronous, active-high reset
//   input_data   in   IN_W   immediate field from instruction register
//   ext_mode     in   2      00 sign, 01 zero, 10 upper, 11 reserved (as 00)
//   load_en      in   1      capture current result into output_reg
//   output_data  out  OUT_W  combinational extension result
//   output_reg   out  OUT_W  registered extension result
//   branch_off   out  OUT_W  output_data << 2 (only with SIGN_EXTEND_SHIFT2_EN)
module sign_extend
  import sign_extend_pkg::*;
#(
  parameter int unsigned IN_W  = IMM_W,
  parameter int unsigned OUT_W = WORD_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  input_data,
  input  logic [1:0]       ext_mode,
  input  logic             load_en,
  output logic [OUT_W-1:0] output_data,
  output logic [OUT_W-1:0] output_reg
`ifdef SIGN_EXTEND_SHIFT2_EN
  ,
  output logic [OUT_W-1:0] branch_off
`endif
);

  ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_ext_core (
    .input_data  (input_data),
    .ext_mode    (ext_mode),
    .output_data (output_data)
  );

  // Holding register; reset wins over load_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      output_reg <= '0;
    end else if (load_en) begin
      output_reg <= output_data;
    end
  end

`ifdef SIGN_EXTEND_SHIFT2_EN
  logic [OUT_W-1:0] branch_off_reg;

  // Word offset to byte offset for branch targets.
  assign branch_off = {output_data[OUT_W-3:0], 2'b00};

  // Registered branch offset, same reset/load rules as output_reg.
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_off_reg <= '0;
    end else if (load_en) begin
      branch_off_reg <= branch_off;
    end
  end
`endif

endmodule : sign_extend

// File: tb/tb_sign_extend.sv
// Directed self-checking bench for sign_extend.
module tb_sign_extend;

  logic        clk;
  logic        reset;
  logic [15:0] input_data;
  logic [1:0]  ext_mode;
  logic        load_en;
  logic [31:0] output_data;
  logic [31:0] output_reg;
`ifdef SIGN_EXTEND_SHIFT2_EN
  logic [31:0] branch_off;
`endif

  int checks;
  int errors;

  sign_extend dut (
    .clk         (clk),
    .reset       (reset),
    .input_data  (input_data),
    .ext_mode    (ext_mode),
    .load_en     (load_en),
    .output_data (output_data),
    .output_reg  (output_reg)
`ifdef SIGN_EXTEND_SHIFT2_EN
    ,
    .branch_off  (branch_off)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Combinational vector, applied away from clock edges.
  task automatic apply_vec(input string tag, input logic [1:0] mode, input logic [15:0] imm,
                           input logic [31:0] exp, input logic [31:0] exp_boff);
    @(negedge clk);
    ext_mode   = mode;
    input_data = imm;
    #1;
    check(tag, output_data, exp);
`ifdef SIGN_EXTEND_SHIFT2_EN
    check({tag, "_boff"}, branch_off, exp_boff);
`else
    if (exp_boff === 32'hx) check(tag, 32'h0, 32'h1);
`endif
  endtask

  // Drive inputs at negedge, check output_reg just after the next rising edge.
  task automatic reg_step(input string tag, input logic rst, input logic ld,
                          input logic [1:0] mode, input logic [15:0] imm,
                          input logic [31:0] exp_reg);
    @(negedge clk);
    reset      = rst;
    load_en    = ld;
    ext_mode   = mode;
    input_data = imm;
    @(posedge clk);
    #1;
    check(tag, output_reg, exp_reg);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    load_en    = 1'b0;
    ext_mode   = 2'b00;
    input_data = 16'h0000;

    @(posedge clk);
    #1;
    check("reset_reg", output_reg, 32'h0000_0000);
    check("reset_data", output_data, 32'h0000_0000);

    @(negedge clk);
    reset = 1'b0;

    apply_vec("sign_0000",  2'b00, 16'h0000, 32'h0000_0000, 32'h0000_0000);
    apply_vec("sign_ffff",  2'b00, 16'hFFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFC);
    apply_vec("sign_7fff",  2'b00, 16'h7FFF, 32'h0000_7FFF, 32'h0001_FFFC);
    apply_vec("sign_8000",  2'b00, 16'h8000, 32'hFFFF_8000, 32'hFFFE_0000);
    apply_vec("sign_0001",  2'b00, 16'h0001, 32'h0000_0001, 32'h0000_0004);
    apply_vec("zero_ffff",  2'b01, 16'hFFFF, 32'h0000_FFFF, 32'h0003_FFFC);
    apply_vec("zero_8000",  2'b01, 16'h8000, 32'h0000_8000, 32'h0002_0000);
    apply_vec("upper_1234", 2'b10, 16'h1234, 32'h1234_0000, 32'h48D0_0000);
    apply_vec("upper_ffff", 2'b10, 16'hFFFF, 32'hFFFF_0000, 32'hFFFC_0000);
    apply_vec("rsvd_8001",  2'b11, 16'h8001, 32'hFFFF_8001, 32'hFFFE_0004);
    apply_vec("rsvd_7fff",  2'b11, 16'h7FFF, 32'h0000_7FFF, 32'h0001_FFFC);

    reg_step("reg_load_1234", 1'b0, 1'b1, 2'b00, 16'h1234, 32'h0000_1234);
    reg_step("reg_rst_prio",  1'b1, 1'b1, 2'b00, 16'hFFFF, 32'h0000_0000);
    check("data_during_rst", output_data, 32'hFFFF_FFFF);
    reg_step("reg_load_ffff", 1'b0, 1'b1, 2'b00, 16'hFFFF, 32'hFFFF_FFFF);
    reg_step("reg_hold_1",    1'b0, 1'b0, 2'b00, 16'h0001, 32'hFFFF_FFFF);
    reg_step("reg_hold_2",    1'b0, 1'b0, 2'b10, 16'h1234, 32'hFFFF_FFFF);
    check("data_while_hold", output_data, 32'h1234_0000);
    reg_step("reg_load_upper", 1'b0, 1'b1, 2'b10, 16'h1234, 32'h1234_0000);
    reg_step("reg_rst_noload", 1'b1, 1'b0, 2'b01, 16'hABCD, 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sign_extend
